// File: rtl/i2c_pkg.sv
// ----------------------------------------------------------------------------
// i2c_pkg
//   Shared types and constants for the I2C master datapath.
//
//   scl_gen_state_t : phase state of the SCL generator (i2c_scl_gen)
//   MIN_HALF_PERIOD : smallest half-period (clk cycles) the generator runs at;
//                     a phase must be long enough to hold a mid-phase tick
//   SYNC_STAGES     : depth of the line-sense synchronizers (i2c_sync2)
// ----------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [1:0] {
        SCL_IDLE      = 2'd0,
        SCL_HIGH_WAIT = 2'd1,
        SCL_HIGH      = 2'd2,
        SCL_LOW       = 2'd3
    } scl_gen_state_t;

    localparam int MIN_HALF_PERIOD = 4;
    localparam int SYNC_STAGES     = 2;

endpackage

// File: rtl/i2c_sync2.sv
// ----------------------------------------------------------------------------
// i2c_sync2
//   Generic flop-chain synchronizer for an asynchronous open-drain line sense.
//   Resets to 1 because an idle I2C line reads high.
//
//   clk : system clock
//   rst : synchronous, active-high reset (chain loads 1)
//   d   : asynchronous line input
//   q   : synchronized line, SYNC_STAGES clk cycles behind d
// ----------------------------------------------------------------------------
module i2c_sync2
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/i2c_scl_gen.sv
// ----------------------------------------------------------------------------
// i2c_scl_gen
//   SCL waveform generator for the I2C master. Produces an SCL clock with a
//   programmable half-period, one scl_tick at the midpoint of every phase
//   (high-phase tick = sample point, low-phase tick = SDA change point) and
//   honours slave clock stretching: a high phase only starts counting once
//   the synchronized SCL line is seen high. This block owns the SCL pull-down.
//
//   Optional build macro: I2C_SCL_TIMEOUT_EN
//     defined   : a stretch longer than stretch_limit cycles pulses
//                 timeout_err, returns to IDLE and stays there until run is
//                 dropped and raised again (stretch_limit = 0 disables it)
//     undefined : HIGH_WAIT waits forever, timeout_err is constant 0
//
//   Ports
//     clk            : system clock
//     rst            : synchronous, active-high reset
//     en             : block enable; 0 forces IDLE and releases SCL
//     run            : request clocking (FSM busy); sampled at end of HIGH
//     half_period    : clk cycles per SCL phase, clamped to >= 4
//     scl_in         : raw SCL line sense (asynchronous)
//     stretch_limit  : max HIGH_WAIT cycles (timeout build only)
//     scl_drive_low  : 1 = pull SCL low
//     scl_tick       : one-cycle pulse at the midpoint of each phase
//     scl_high_phase : 1 in high / idle phases, 0 in the low phase
//     scl_stretch    : 1 while waiting for a released SCL to read high
//     timeout_err    : one-cycle pulse on stretch timeout
//     dbg_state      : current generator state
//
//   All outputs decode registered state only; nothing is combinational from
//   an input.
// ----------------------------------------------------------------------------
module i2c_scl_gen
    import i2c_pkg::*;
#(
    parameter int DIV_W     = 16,
    parameter int TIMEOUT_W = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 run,
    input  logic [DIV_W-1:0]     half_period,
    input  logic                 scl_in,
    input  logic [TIMEOUT_W-1:0] stretch_limit,
    output logic                 scl_drive_low,
    output logic                 scl_tick,
    output logic                 scl_high_phase,
    output logic                 scl_stretch,
    output logic                 timeout_err,
    output scl_gen_state_t       dbg_state
);

    scl_gen_state_t   state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] hp_q, hp_d;
    logic [DIV_W-1:0] hp_new;
    logic             phase_last;
    logic             scl_s;

    i2c_sync2 u_scl_sync (
        .clk (clk),
        .rst (rst),
        .d   (scl_in),
        .q   (scl_s)
    );

    // Half-period is captured only when a counted phase begins, so a change
    // on half_period never bends a phase already in progress.
    assign hp_new     = (half_period < DIV_W'(MIN_HALF_PERIOD)) ?
                        DIV_W'(MIN_HALF_PERIOD) : half_period;
    assign phase_last = (cnt_q == hp_q - DIV_W'(1));

`ifdef I2C_SCL_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] scnt_q, scnt_d;
    logic                 lock_q, lock_d;
    logic                 terr_q, terr_d;
    logic                 stretch_expired;

    // scnt_q holds the number of HIGH_WAIT cycles already spent, so this
    // fires in the stretch_limit-th HIGH_WAIT cycle.
    assign stretch_expired = (stretch_limit != '0) &&
                             (scnt_q + TIMEOUT_W'(1) == stretch_limit);
`else
    logic unused_stretch_limit;
    assign unused_stretch_limit = ^stretch_limit;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SCL_IDLE;
            cnt_q   <= '0;
            hp_q    <= DIV_W'(MIN_HALF_PERIOD);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hp_q    <= hp_d;
        end
    end

`ifdef I2C_SCL_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            scnt_q <= '0;
            lock_q <= 1'b0;
            terr_q <= 1'b0;
        end else begin
            scnt_q <= scnt_d;
            lock_q <= lock_d;
            terr_q <= terr_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hp_d    = hp_q;
`ifdef I2C_SCL_TIMEOUT_EN
        scnt_d  = '0;
        terr_d  = 1'b0;
        // After a timeout, stay out until run is seen low at least once.
        lock_d  = run ? lock_q : 1'b0;
`endif
        if (!en) begin
            state_d = SCL_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                SCL_IDLE: begin
                    cnt_d = '0;
`ifdef I2C_SCL_TIMEOUT_EN
                    if (run && !lock_q) state_d = SCL_HIGH_WAIT;
`else
                    if (run) state_d = SCL_HIGH_WAIT;
`endif
                end
                SCL_HIGH_WAIT: begin
                    cnt_d = '0;
                    if (scl_s) begin
                        state_d = SCL_HIGH;
                        hp_d    = hp_new;
                    end
`ifdef I2C_SCL_TIMEOUT_EN
                    else if (stretch_expired) begin
                        state_d = SCL_IDLE;
                        terr_d  = 1'b1;
                        lock_d  = 1'b1;
                    end else begin
                        scnt_d = scnt_q + TIMEOUT_W'(1);
                    end
`endif
                end
                SCL_HIGH: begin
                    // A falling scl_s here (glitch / other master) is ignored.
                    if (phase_last) begin
                        cnt_d = '0;
                        if (run) begin
                            state_d = SCL_LOW;
                            hp_d    = hp_new;
                        end else begin
                            state_d = SCL_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
                SCL_LOW: begin
                    // A low phase always runs to completion, run or not.
                    if (phase_last) begin
                        cnt_d   = '0;
                        state_d = SCL_HIGH_WAIT;
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
                default: begin
                    state_d = SCL_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign scl_drive_low  = (state_q == SCL_LOW);
    assign scl_high_phase = (state_q != SCL_LOW);
    assign scl_stretch    = (state_q == SCL_HIGH_WAIT);
    assign scl_tick       = ((state_q == SCL_HIGH) || (state_q == SCL_LOW)) &&
                            (cnt_q == (hp_q >> 1));
    assign dbg_state      = state_q;

`ifdef I2C_SCL_TIMEOUT_EN
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_scl_gen.sv
// ----------------------------------------------------------------------------
// tb_i2c_scl_gen
//   Self-checking bench for i2c_scl_gen. The SCL line is modelled as
//   open-drain: scl_in = !scl_drive_low && !slave_hold.
//   Reference model: per-cycle expected output tuples built phase by phase
//   from the timing rules (phase length = max(half_period,4) at phase entry,
//   tick at len/2, stretch length = hold + 3 synchronizer/decision cycles).
// ----------------------------------------------------------------------------
module tb_i2c_scl_gen;
    import i2c_pkg::*;

    localparam int DIV_W     = 16;
    localparam int TIMEOUT_W = 20;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic                 run;
    logic [DIV_W-1:0]     half_period;
    logic                 scl_in;
    logic [TIMEOUT_W-1:0] stretch_limit;
    logic                 scl_drive_low;
    logic                 scl_tick;
    logic                 scl_high_phase;
    logic                 scl_stretch;
    logic                 timeout_err;
    scl_gen_state_t       dbg_state;
    logic                 slave_hold;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- clock / line model ----------------
    always #5 clk = ~clk;

    assign scl_in = !scl_drive_low && !slave_hold;

    i2c_scl_gen #(
        .DIV_W     (DIV_W),
        .TIMEOUT_W (TIMEOUT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .run            (run),
        .half_period    (half_period),
        .scl_in         (scl_in),
        .stretch_limit  (stretch_limit),
        .scl_drive_low  (scl_drive_low),
        .scl_tick       (scl_tick),
        .scl_high_phase (scl_high_phase),
        .scl_stretch    (scl_stretch),
        .timeout_err    (timeout_err),
        .dbg_state      (dbg_state)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic dl;
        logic tick;
        logic hph;
        logic st;
    } obs_t;

    obs_t exp_q[$];
    logic hold_q[$];

    typedef struct {
        int hp_in;
        int exp_len;
        int exp_tick;
    } vec_t;

    vec_t vecs[8];

    logic tr_dl[64];
    logic tr_tk[64];
    logic tr_hp[64];
    logic tr_st[64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (dbg_state != SCL_IDLE && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(dbg_state == SCL_IDLE), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_dl(input logic val, input string name);
        int n;
        n = 0;
        while (scl_drive_low !== val && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(scl_drive_low), 32'(val));
    endtask

    function automatic int clamp_hp(input int v);
        return (v < 4) ? 4 : v;
    endfunction

    task automatic model_phase(input logic low, input int len);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back('{dl: low, tick: (i == len / 2), hph: !low, st: 1'b0});
            hold_q.push_back(1'b0);
        end
    endtask

    task automatic model_wait(input int held, input int len);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back('{dl: 1'b0, tick: 1'b0, hph: 1'b1, st: 1'b1});
            hold_q.push_back(i < held);
        end
    endtask

    task automatic model_idle(input int len);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back('{dl: 1'b0, tick: 1'b0, hph: 1'b1, st: 1'b0});
            hold_q.push_back(1'b0);
        end
    endtask

    // ---------------- table-driven phase timing ----------------
    task automatic run_vectors();
        int n, hs, ls, le, th, tl;
        for (int v = 0; v < 8; v++) begin
            half_period = DIV_W'(vecs[v].hp_in);
            run = 1'b1;
            n = 3 * vecs[v].exp_len + 12;
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                tr_dl[i] = scl_drive_low;
                tr_tk[i] = scl_tick;
                tr_hp[i] = scl_high_phase;
                tr_st[i] = scl_stretch;
            end
            run = 1'b0;
            hs = -1; ls = -1; le = -1; th = -1; tl = -1;
            for (int i = 0; i < n; i++) begin
                if (hs < 0 && !tr_st[i]) hs = i;
                if (ls < 0 && tr_dl[i]) ls = i;
                if (ls >= 0 && le < 0 && i > ls && !tr_dl[i]) le = i;
                if (hs >= 0 && th < 0 && i >= hs && tr_tk[i]) th = i;
                if (ls >= 0 && tl < 0 && i >= ls && tr_tk[i]) tl = i;
            end
            check($sformatf("vec%0d_high_len", v), 32'(ls - hs), 32'(vecs[v].exp_len));
            check($sformatf("vec%0d_low_len", v), 32'(le - ls), 32'(vecs[v].exp_len));
            check($sformatf("vec%0d_tick_hi_off", v), 32'(th - hs), 32'(vecs[v].exp_tick));
            check($sformatf("vec%0d_tick_lo_off", v), 32'(tl - ls), 32'(vecs[v].exp_tick));
            check($sformatf("vec%0d_tick_lo_phase", v), 32'((tl >= 0) ? tr_hp[tl] : 1'b1), 32'd0);
            wait_idle($sformatf("vec%0d_idle", v));
        end
    endtask

    // ---------------- stretch: hold SCL low 50 cycles after LOW ----------------
    task automatic stretch_test();
        int bad, cnt;
        half_period = DIV_W'(10);
        run = 1'b1;
        wait_dl(1'b1, "st_low_start");
        slave_hold = 1'b1;
        wait_dl(1'b0, "st_low_end");
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (!scl_stretch || scl_tick || scl_drive_low) bad++;
            @(negedge clk);
        end
        check("st_hold_cycles_bad", 32'(bad), 32'd0);
        slave_hold = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!scl_stretch) break;
            cnt++;
        end
        check("st_release_latency_ok", 32'(cnt >= 2 && cnt <= 3), 32'd1);
        cnt = 0;
        while (!scl_tick && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("st_tick_after_high", 32'(cnt), 32'd5);
        check("st_tick_high_phase", 32'(scl_high_phase), 32'd1);
        run = 1'b0;
        wait_idle("st_idle");
    endtask

    // ---------------- abort at HIGH cnt=4 ----------------
    task automatic abort_test(input logic use_rst);
        int n, ticks;
        half_period = DIV_W'(10);
        run = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (scl_stretch && n < 20);
        check($sformatf("ab%0d_high_entry", use_rst), 32'(dbg_state == SCL_HIGH), 32'd1);
        repeat (4) @(negedge clk);
        check($sformatf("ab%0d_no_tick_cnt4", use_rst), 32'(scl_tick), 32'd0);
        if (use_rst) rst = 1'b1;
        else en = 1'b0;
        @(negedge clk);
        check($sformatf("ab%0d_outputs", use_rst),
              {27'd0, scl_drive_low, scl_tick, scl_high_phase, scl_stretch, timeout_err},
              32'b00100);
        check($sformatf("ab%0d_state", use_rst), 32'(dbg_state == SCL_IDLE), 32'd1);
        run = 1'b0;
        rst = 1'b0;
        en  = 1'b1;
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (scl_tick || scl_drive_low) ticks++;
        end
        check($sformatf("ab%0d_quiet_after", use_rst), 32'(ticks), 32'd0);
    endtask

    // ---------------- randomized episodes vs reference model ----------------
    task automatic random_episode(input int ep);
        int hp1, hp2, c_chg, n_per, pre_end, fin_end, r_drop, ln, held;
        obs_t got;
        hp1   = int'($urandom_range(0, 13));
        hp2   = int'($urandom_range(0, 13));
        c_chg = int'($urandom_range(0, 90));
        n_per = int'($urandom_range(0, 3));
        exp_q.delete();
        hold_q.delete();
        pre_end = -1;
        // From IDLE the synchronized line is already high: one HIGH_WAIT cycle.
        model_wait(0, 1);
        for (int p = 0; p <= n_per; p++) begin
            ln = clamp_hp((exp_q.size() > c_chg) ? hp2 : hp1);
            model_phase(1'b0, ln);
            if (p == n_per) break;
            pre_end = exp_q.size() - 1;
            ln = clamp_hp((exp_q.size() > c_chg) ? hp2 : hp1);
            model_phase(1'b1, ln);
            held = int'($urandom_range(0, 8));
            model_wait(held, held + 3);
        end
        fin_end = exp_q.size() - 1;
        model_idle(6);
        r_drop = int'($urandom_range(pre_end + 1, fin_end));

        half_period = DIV_W'(hp1);
        run = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            got = '{dl: scl_drive_low, tick: scl_tick, hph: scl_high_phase, st: scl_stretch};
            check($sformatf("ep%0d_cyc%0d", ep, i), {27'd0, got, timeout_err}, {27'd0, exp_q[i], 1'b0});
            slave_hold = hold_q[i];
            if (i == c_chg) half_period = DIV_W'(hp2);
            if (i == r_drop) run = 1'b0;
        end
        slave_hold = 1'b0;
        run = 1'b0;
    endtask

`ifdef I2C_SCL_TIMEOUT_EN
    // ---------------- stretch timeout ----------------
    task automatic timeout_test();
        int first_at, pulses;
        stretch_limit = TIMEOUT_W'(100);
        half_period = DIV_W'(10);
        slave_hold = 1'b1;
        repeat (4) @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        check("to_wait_entry", 32'(scl_stretch), 32'd1);
        first_at = -1;
        pulses = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (timeout_err) begin
                pulses++;
                if (first_at < 0) first_at = i;
            end
        end
        check("to_pulses", 32'(pulses), 32'd1);
        check("to_offset", 32'(first_at), 32'd100);
        check("to_idle_locked", 32'(dbg_state == SCL_IDLE && !scl_stretch && !scl_drive_low), 32'd1);
        run = 1'b0;
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        check("to_rearm", 32'(scl_stretch), 32'd1);
        slave_hold = 1'b0;
        stretch_limit = '0;
        run = 1'b0;
        wait_idle("to_cleanup");
    endtask
`endif

    // ---------------- main ----------------
    initial begin
        rst           = 1'b1;
        en            = 1'b1;
        run           = 1'b0;
        half_period   = DIV_W'(10);
        slave_hold    = 1'b0;
        stretch_limit = '0;

        vecs[0] = '{hp_in: 0,  exp_len: 4,  exp_tick: 2};
        vecs[1] = '{hp_in: 1,  exp_len: 4,  exp_tick: 2};
        vecs[2] = '{hp_in: 3,  exp_len: 4,  exp_tick: 2};
        vecs[3] = '{hp_in: 4,  exp_len: 4,  exp_tick: 2};
        vecs[4] = '{hp_in: 5,  exp_len: 5,  exp_tick: 2};
        vecs[5] = '{hp_in: 7,  exp_len: 7,  exp_tick: 3};
        vecs[6] = '{hp_in: 10, exp_len: 10, exp_tick: 5};
        vecs[7] = '{hp_in: 13, exp_len: 13, exp_tick: 6};

        repeat (3) @(negedge clk);
        check("reset_outputs",
              {27'd0, scl_drive_low, scl_tick, scl_high_phase, scl_stretch, timeout_err},
              32'b00100);
        check("reset_state", 32'(dbg_state == SCL_IDLE), 32'd1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_no_run", 32'(dbg_state == SCL_IDLE && !scl_tick), 32'd1);

        run_vectors();
        stretch_test();
        abort_test(1'b0);
        abort_test(1'b1);
        for (int ep = 0; ep < 25; ep++) random_episode(ep);
`ifdef I2C_SCL_TIMEOUT_EN
        timeout_test();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2c_scl_gen.md
Name: i2c_scl_gen

Overview:
Upstream timing stage for the I2C master FSM. It generates the SCL waveform with a programmable half-period and emits the scl_tick / scl_high_phase pair that the FSM consumes. It supports slave clock stretching: the high phase only starts counting once the synchronized SCL line is actually seen high. It owns the SCL open-drain pull-down; the FSM only drives SDA.

Parameters:
DIV_W, 16, width of the half-period divider and of the internal phase counter
TIMEOUT_W, 20, width of the stretch-timeout counter (used only with I2C_SCL_TIMEOUT_EN)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset; one clock domain only
en  input  1  block enable; 0 forces IDLE and releases SCL
run  input  1  request clocking; tie to the FSM busy output
half_period  input  DIV_W  clk cycles per SCL phase; values below 4 are clamped to 4
scl_in  input  1  raw SCL line sense (asynchronous)
stretch_limit  input  TIMEOUT_W  maximum HIGH_WAIT cycles (only with I2C_SCL_TIMEOUT_EN)
scl_drive_low  output  1  1 = pull SCL low
scl_tick  output  1  one-cycle pulse at the midpoint of each SCL phase
scl_high_phase  output  1  1 while in a high or idle phase, 0 while in the low phase
scl_stretch  output  1  1 while waiting for a released SCL to read high
timeout_err  output  1  one-cycle pulse on stretch timeout (only with I2C_SCL_TIMEOUT_EN, else 0)

Behaviour:
- scl_in passes through a 2-flop synchronizer (scl_s) before use.
- All outputs decode only registered state and counter; there is no input-to-output combinational path.
- Reset values: state=IDLE, cnt=0, scl_drive_low=0, scl_tick=0, scl_high_phase=1, scl_stretch=0, timeout_err=0.
- hp_q: latched at every phase entry as max(half_period, 4). A half_period change takes effect only at the next phase boundary.
- States:
  - IDLE: SCL released, scl_high_phase=1. On en && run, go to HIGH_WAIT.
  - HIGH_WAIT: SCL released, scl_stretch=1, cnt held at 0, no ticks. When scl_s==1, go to HIGH on the next cycle.
  - HIGH: SCL released, cnt counts 0..hp_q-1.
    - scl_tick=1 with scl_high_phase=1 in the cycle cnt==hp_q>>1; this is the FSM sample point.
    - At cnt==hp_q-1: if run, go to LOW; otherwise go to IDLE.
  - LOW: scl_drive_low=1, scl_high_phase=0, cnt counts 0..hp_q-1.
    - scl_tick=1 in the cycle cnt==hp_q>>1; this is the SDA change point.
    - At cnt==hp_q-1, always go to HIGH_WAIT, even if run has dropped. A low phase is never truncated.
- The first phase after IDLE is a high phase, so the FSM's START alignment (tick_high first) holds.
- run is sampled only at the end of HIGH. A run drop mid-LOW completes LOW, HIGH_WAIT and HIGH, then goes to IDLE.
- Exactly one scl_tick per phase; no tick in IDLE or HIGH_WAIT.
- Nominal SCL period = 2*hp_q cycles plus HIGH_WAIT time (at least 2 cycles of synchronizer latency plus the line rise time).
- en=0 overrides everything: the next cycle is IDLE with SCL released, cnt=0 and no tick. A pending tick is dropped.
- rst asserted mid-phase behaves the same as en=0, and all outputs return to their reset values.
- If scl_s falls during HIGH (another master or a glitch), it is ignored; counting continues.

Optional Feature:
Macro I2C_SCL_TIMEOUT_EN.
- Defined:
  - A stretch counter clears on HIGH_WAIT entry and increments each HIGH_WAIT cycle.
  - When it reaches stretch_limit: pulse timeout_err for 1 cycle, go to IDLE, release SCL.
  - The block does not re-enter HIGH_WAIT until run is deasserted and reasserted.
  - stretch_limit=0 disables the timeout.
- Not defined:
  - HIGH_WAIT waits indefinitely.
  - timeout_err is tied to 0, stretch_limit is unused, and no counter logic is synthesized.

Decomposition:
- Package i2c_pkg holds:
  - typedef enum scl_gen_state_t {SCL_IDLE, SCL_HIGH_WAIT, SCL_HIGH, SCL_LOW}
  - localparam MIN_HALF_PERIOD=4
  - localparam SYNC_STAGES=2
- Sub-module i2c_sync2 is a generic 2-flop synchronizer with synchronous reset to 1 (line idle high). It is reused later for SDA sense.

Test Plan:
- The bench models scl_in = !scl_drive_low && !slave_hold, passed through the 2-flop delay.
- Free run: half_period=10, run=1, no stretch.
  - High and low phases are each exactly 10 cycles.
  - Ticks occur at cnt=5 of each phase and alternate scl_high_phase 1,0,1,0.
  - Period is 20 cycles plus HIGH_WAIT (about 2-3 cycles).
- Clamp: half_period=2 -> phases are 4 cycles long, with the tick at cnt=2.
- Stretch: slave_hold=1 for 50 cycles after the LOW end.
  - scl_stretch=1 throughout, no ticks, cnt frozen.
  - HIGH starts 2-3 cycles after release, and the next tick_high comes 5 cycles later.
- Run drop: run goes to 0 at LOW cnt=3 (hp=10).
  - LOW completes 10 cycles, then one HIGH phase with its tick, then IDLE.
  - No further ticks; SCL stays released.
- Abort: en=0 or rst=1 at HIGH cnt=4.
  - Next cycle: IDLE, scl_drive_low=0, no tick at cnt=5, outputs at reset values.
- Timeout (I2C_SCL_TIMEOUT_EN, stretch_limit=100): slave_hold held permanently.
  - timeout_err pulses exactly once, 100 cycles after HIGH_WAIT entry, then the block is in IDLE.
  - It stays in IDLE until run toggles 0 to 1.
